// File: rtl/alu_exec.sv
// Execution-stage ALU: single-cycle ADD/SUB/AND/OR and an iterative shift-add MUL
// with a start/done handshake so the pipeline can stall while a multiply runs.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start_i; single-cycle ops and invalid codes finish here
// MUL_RUN | shift-add multiply iterating, one partial product per cycle
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   mcand, mcand_next;
    logic [WIDTH-1:0]   mplier, mplier_next;
    logic [WIDTH-1:0]   acc, acc_next;
    logic [WIDTH-1:0]   acc_sum;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [WIDTH-1:0]   data_next;
    logic               zero_next;
    logic               err_next;
    logic               done_next;

    assign busy_o = (state == MUL_RUN);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            data_o <= '0;
            zero_o <= 1'b0;
            err_o  <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state  <= state_next;
            mcand  <= mcand_next;
            mplier <= mplier_next;
            acc    <= acc_next;
            cnt    <= cnt_next;
            data_o <= data_next;
            zero_o <= zero_next;
            err_o  <= err_next;
            done_o <= done_next;
        end
    end

    always_comb begin
        state_next  = state;
        mcand_next  = mcand;
        mplier_next = mplier;
        acc_next    = acc;
        cnt_next    = cnt;
        acc_sum     = acc + (mplier[0] ? mcand : '0);
        data_next   = data_o;
        zero_next   = zero_o;
        err_next    = err_o;
        done_next   = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    case (ALUCtrl_i)
                        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                            case (ALUCtrl_i)
                                OP_ADD:  data_next = data1_i + data2_i;
                                OP_SUB:  data_next = data1_i - data2_i;
                                OP_AND:  data_next = data1_i & data2_i;
                                default: data_next = data1_i | data2_i;
                            endcase
                            zero_next = (data_next == '0);
                            err_next  = 1'b0;
                            done_next = 1'b1;
                        end
                        OP_MUL: begin
                            // Result registers hold their old value until the multiply completes.
                            mcand_next  = data1_i;
                            mplier_next = data2_i;
                            acc_next    = '0;
                            cnt_next    = '0;
                            state_next  = MUL_RUN;
                        end
                        default: begin
                            data_next = '0;
                            zero_next = 1'b1;
                            err_next  = 1'b1;
                            done_next = 1'b1;
                        end
                    endcase
                end
            end
            MUL_RUN: begin
                acc_next    = acc_sum;
                mcand_next  = mcand << 1;
                mplier_next = mplier >> 1;
                cnt_next    = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    data_next  = acc_sum;
                    zero_next  = (acc_sum == '0);
                    err_next   = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed scenarios plus randomized traffic,
// compared every cycle against a cycle-count/arithmetic reference model.
module tb_alu_exec;

    localparam int WIDTH = 32;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    logic             clk_i;
    logic             rst_i;
    logic             start_i;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [WIDTH-1:0] data_o;
    logic             zero_o;
    logic             done_o;
    logic             busy_o;
    logic             err_o;

    alu_exec #(.WIDTH(WIDTH)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .ALUCtrl_i (ALUCtrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .data_o    (data_o),
        .zero_o    (zero_o),
        .done_o    (done_o),
        .busy_o    (busy_o),
        .err_o     (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural outputs plus the number of cycles a multiply still needs.
    logic [WIDTH-1:0] m_data;
    logic             m_zero;
    logic             m_err;
    logic             m_done;
    logic [WIDTH-1:0] m_mul;
    int               m_busy_left;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst_v, input logic st, input logic [2:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] prod;
        rst_i     = rst_v;
        start_i   = st;
        ALUCtrl_i = op;
        data1_i   = a;
        data2_i   = b;
        @(posedge clk_i);
        m_done = 1'b0;
        if (!rst_v) begin
            m_data      = '0;
            m_zero      = 1'b0;
            m_err       = 1'b0;
            m_busy_left = 0;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                m_data = m_mul;
                m_zero = (m_mul == '0);
                m_err  = 1'b0;
                m_done = 1'b1;
            end
        end else if (st) begin
            if (op == OP_MUL) begin
                prod        = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
                m_mul       = prod[WIDTH-1:0];
                m_busy_left = WIDTH;
            end else begin
                case (op)
                    OP_ADD:  m_data = a + b;
                    OP_SUB:  m_data = a - b;
                    OP_AND:  m_data = a & b;
                    OP_OR:   m_data = a | b;
                    default: m_data = '0;
                endcase
                m_zero = (m_data == '0);
                m_err  = (op > OP_MUL);
                m_done = 1'b1;
            end
        end
        #1;
        check("data", data_o, m_data);
        check("zero", {{(WIDTH-1){1'b0}}, zero_o}, {{(WIDTH-1){1'b0}}, m_zero});
        check("err",  {{(WIDTH-1){1'b0}}, err_o},  {{(WIDTH-1){1'b0}}, m_err});
        check("done", {{(WIDTH-1){1'b0}}, done_o}, {{(WIDTH-1){1'b0}}, m_done});
        check("busy", {{(WIDTH-1){1'b0}}, busy_o}, {{(WIDTH-1){1'b0}}, (m_busy_left > 0)});
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
    endtask

    function automatic logic [WIDTH-1:0] rand_operand();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        m_data = '0; m_zero = 1'b0; m_err = 1'b0; m_done = 1'b0; m_mul = '0; m_busy_left = 0;
        rst_i = 1'b0; start_i = 1'b0; ALUCtrl_i = '0; data1_i = '0; data2_i = '0;

        // reset, then quiet cycles: nothing completes without a request
        step(1'b0, 1'b0, OP_ADD, '0, '0);
        step(1'b0, 1'b0, OP_ADD, '0, '0);
        for (int i = 0; i < 3; i++) idle();

        // back-to-back single-cycle ops
        step(1'b1, 1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h1);
        check("add_wrap", data_o, 32'h0);
        check("add_zero", {31'b0, zero_o}, 32'h1);
        step(1'b1, 1'b1, OP_SUB, 32'd5, 32'd7);
        check("sub_wrap", data_o, 32'hFFFF_FFFE);
        step(1'b1, 1'b1, OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        check("and", data_o, 32'h00F0_00F0);
        step(1'b1, 1'b1, OP_OR, 32'h1, 32'h8);
        check("or", data_o, 32'h9);
        check("done_4th", {31'b0, done_o}, 32'h1);
        idle();

        // multiplies with directed operands
        step(1'b1, 1'b1, OP_MUL, 32'd12, 32'd13);
        for (int k = 1; k <= WIDTH; k++) idle();
        check("mul_12x13", data_o, 32'd156);
        step(1'b1, 1'b1, OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int k = 1; k <= WIDTH; k++) idle();
        check("mul_ones", data_o, 32'd1);
        step(1'b1, 1'b1, OP_MUL, 32'h0001_0000, 32'h0001_0000);
        for (int k = 1; k <= WIDTH; k++) idle();
        check("mul_ovf", data_o, 32'd0);
        check("mul_ovf_zero", {31'b0, zero_o}, 32'h1);

        // start_i ignored while busy; ADD right after done is accepted
        step(1'b1, 1'b1, OP_MUL, 32'd7, 32'd9);
        for (int k = 1; k <= WIDTH + 2; k++) begin
            step(1'b1, (k == 5 || k == WIDTH || k == WIDTH + 1), OP_ADD, 32'd100, 32'd1);
            if (k == WIDTH)     check("mul_busy_ignore", data_o, 32'd63);
            if (k == WIDTH + 1) check("add_after_mul", data_o, 32'd101);
        end

        // invalid codes, each followed by a valid ADD
        for (int c = 5; c <= 7; c++) begin
            step(1'b1, 1'b1, 3'(c), 32'h1234, 32'h5678);
            check("inv_err", {31'b0, err_o}, 32'h1);
            idle();
            step(1'b1, 1'b1, OP_ADD, 32'd2, 32'd3);
            check("inv_clear", {31'b0, err_o}, 32'h0);
        end

        // reset in the middle of a multiply
        step(1'b1, 1'b1, OP_MUL, 32'd1000, 32'd1000);
        for (int k = 1; k < 10; k++) idle();
        step(1'b0, 1'b0, OP_ADD, '0, '0);
        check("rst_mid_busy", {31'b0, busy_o}, 32'h0);
        for (int k = 0; k < WIDTH + 8; k++) idle();
        step(1'b1, 1'b1, OP_MUL, 32'd3, 32'd4);
        for (int k = 1; k <= WIDTH; k++) idle();
        check("mul_3x4", data_o, 32'd12);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) != 0), $urandom_range(0, 1) == 1,
                 3'($urandom_range(0, 7)), rand_operand(), rand_operand());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
